// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder sequencer: state encoding,
// default width and the bit-counter width helper.
package serial_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/FullAdder_1bit.sv
// Single-bit full adder cell, reused by the serial adder as its whole datapath.
module FullAdder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: LSB-first through one FullAdder_1bit, WIDTH+2 cycles/op.
// Optional subtract mode is enabled with the SERIAL_ADD_SUB_EN macro.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | one bit per cycle through the full adder
// DONE  | result held, out_valid=1 until out_ready
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             carry_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;
  logic [WIDTH-1:0] res_next;

  FullAdder_1bit u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Subtraction is a + ~b + 1; the forced carry-in replaces cin.
`ifdef SERIAL_ADD_SUB_EN
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub ? 1'b1 : cin;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  assign res_next  = {fa_sum, res_sr[WIDTH-1:1]};
  assign in_ready  = rst & (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_sr    <= '0;
      b_sr    <= '0;
      res_sr  <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_sr    <= a;
            b_sr    <= b_load;
            carry_q <= carry_load;
            cnt_q   <= '0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          res_sr  <= res_next;
          carry_q <= fa_cout;
          if (cnt_q == CNT_LAST) begin
            sum_q   <= res_next;
            cout_q  <= fa_cout;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8; subtract cases run when
// SERIAL_ADD_SUB_EN is defined.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int total = 0;
  int bad   = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    tick(); tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (sum !== 8'h00) begin bad++; $display("FAIL reset_sum got=%h exp=00", sum); end
    total++; if (cout !== 1'b0) begin bad++; $display("FAIL reset_cout got=%b exp=0", cout); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b1;
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
  endtask

  // One full operation with out_ready high; checks latency, result and return to IDLE.
  task automatic test_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic tcin, input logic tsub,
                         input logic [W-1:0] exp_sum, input logic exp_cout);
    int n;
    out_ready = 1'b1;
    a = ta; b = tb_; cin = tcin; sub = tsub; in_valid = 1'b1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL %s_ready got=%b exp=1", name, in_ready); end
    tick();
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin tick(); n++; end
    total++; if (n != W) begin bad++; $display("FAIL %s_latency got=%0d exp=%0d", name, n, W); end
    total++; if (sum !== exp_sum) begin bad++; $display("FAIL %s_sum got=%h exp=%h", name, sum, exp_sum); end
    total++; if (cout !== exp_cout) begin bad++; $display("FAIL %s_cout got=%b exp=%b", name, cout, exp_cout); end
    tick();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL %s_return got_valid=%b got_ready=%b exp=0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    int n;
    out_ready = 1'b0;
    a = 8'h3C; b = 8'h42; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin tick(); n++; end
    total++; if (n != W) begin bad++; $display("FAIL bp_latency got=%0d exp=%0d", n, W); end
    a = 8'h11; b = 8'h22; cin = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (out_valid !== 1'b1 || sum !== 8'h7E || cout !== 1'b0 || in_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold cyc=%0d got v=%b s=%h c=%b r=%b exp v=1 s=7e c=0 r=0",
                        i, out_valid, sum, cout, in_ready);
      end
    end
    out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL bp_release got v=%b r=%b busy=%b exp 0/1/0", out_valid, in_ready, busy);
    end
    in_valid = 1'b0;
    total++; if (sum !== 8'h7E) begin bad++; $display("FAIL bp_not_taken got=%h exp=7e", sum); end
  endtask

  task automatic test_reset_mid_run();
    bit saw_valid;
    saw_valid = 1'b0;
    a = 8'h55; b = 8'h66; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(); if (out_valid) saw_valid = 1'b1; end
    rst = 1'b0;
    tick();
    total++; if (busy !== 1'b0 || sum !== 8'h00 || cout !== 1'b0 || in_ready !== 1'b0) begin
      bad++; $display("FAIL midrun_reset got busy=%b s=%h c=%b r=%b exp 0/00/0/0", busy, sum, cout, in_ready);
    end
    tick();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin tick(); if (out_valid) saw_valid = 1'b1; end
    total++; if (saw_valid) begin bad++; $display("FAIL midrun_no_valid got=1 exp=0"); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrun_idle got=%b exp=1", in_ready); end
  endtask

  task automatic test_reset_vs_accept();
    a = 8'h01; b = 8'h01; in_valid = 1'b1; rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rstacc_ready got=%b exp=0", in_ready); end
    tick();
    in_valid = 1'b0; rst = 1'b1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstacc_busy got=%b exp=0", busy); end
    tick();
  endtask

  initial begin
    test_reset();
    test_op("add_nocarry", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0);
    test_op("add_carry",   8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1);
    test_op("add_alt",     8'hA5, 8'h5A, 1'b0, 1'b0, 8'hFF, 1'b0);
    test_op("add_msb",     8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1);
    test_backpressure();
    test_reset_mid_run();
    test_reset_vs_accept();
`ifdef SERIAL_ADD_SUB_EN
    test_op("sub_borrow",  8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0);
    test_op("sub_noborrow",8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
